// File: rtl/div_pkg.sv
// div_pkg: shared widths, defaults and FSM state type for the 8/4 sequential divider.
package div_pkg;

    localparam int DD_W        = 8;
    localparam int DQ_W        = 4;
    localparam int DIV_LAT_DEF = 10;

    localparam logic [DD_W-1:0] DZ_Q_DEF = 8'hFF;
    localparam logic [DQ_W-1:0] DZ_R_DEF = 4'hF;

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

endpackage

// File: rtl/div_lat_cnt.sv
// div_lat_cnt: loadable down-counter with zero flag for fixed-latency sequential units.
module div_lat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    assign zero = (count == '0);

    // Holds at zero rather than wrapping, so a late dec cannot restart the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else if (load) count <= load_val;
        else if (dec && !zero) count <= count - W'(1);
    end

endmodule

// File: rtl/div_seq.sv
// div_seq: operand sequencer and result capture for the 8/4 sequential divider,
// with divide-by-zero short-circuit that never starts the divider.
module div_seq
    import div_pkg::*;
#(
    parameter int              DIV_LAT = DIV_LAT_DEF,
    parameter logic [DD_W-1:0] DZ_Q    = DZ_Q_DEF,
    parameter logic [DQ_W-1:0] DZ_R    = DZ_R_DEF
) (
    input  logic            CLOCK,
    input  logic            RESET,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [DD_W-1:0] IN_DD,
    input  logic [DQ_W-1:0] IN_DQ,
    output logic            DIV_START,
    output logic [DD_W-1:0] DIV_DD,
    output logic [DQ_W-1:0] DIV_DQ,
    input  logic [DD_W-1:0] DIV_ANS,
    input  logic [DQ_W-1:0] DIV_ARE,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [DD_W-1:0] OUT_Q,
    output logic [DQ_W-1:0] OUT_R,
    output logic            OUT_DZ
);

    localparam int            CW     = $clog2(DIV_LAT) + 1;
    localparam logic [CW-1:0] LAT_M1 = CW'(DIV_LAT - 1);

    state_t state;
    logic   cnt_zero;

    // Loaded in START so that the zero flag lines up with the last WAIT cycle.
    div_lat_cnt #(.W(CW)) u_cnt (
        .clk      (CLOCK),
        .rst      (RESET),
        .load     (state == START),
        .dec      (state == WAIT),
        .load_val (LAT_M1),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            IN_READY  <= 1'b1;
            DIV_START <= 1'b0;
            DIV_DD    <= '0;
            DIV_DQ    <= '0;
            OUT_VALID <= 1'b0;
            OUT_Q     <= '0;
            OUT_R     <= '0;
            OUT_DZ    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (IN_VALID) begin
                    DIV_DD   <= IN_DD;
                    DIV_DQ   <= IN_DQ;
                    IN_READY <= 1'b0;
                    if (IN_DQ == '0) begin
                        OUT_Q     <= DZ_Q;
                        OUT_R     <= DZ_R;
                        OUT_DZ    <= 1'b1;
                        OUT_VALID <= 1'b1;
                        state     <= DONE;
                    end else begin
                        DIV_START <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    DIV_START <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: if (cnt_zero) begin
                    OUT_Q     <= DIV_ANS;
                    OUT_R     <= DIV_ARE;
                    OUT_DZ    <= 1'b0;
                    OUT_VALID <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (OUT_READY) begin
                    OUT_VALID <= 1'b0;
                    IN_READY  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for div_seq with a latency-accurate divider model
// that presents wrong data on every cycle except the intended sampling cycle.
module tb_div_seq;
    import div_pkg::*;

    localparam int LAT = 10;

    typedef struct packed {
        logic [7:0] dd;
        logic [3:0] dq;
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
    } vec_t;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b0;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [7:0] IN_DD = '0;
    logic [3:0] IN_DQ = '0;
    logic       DIV_START;
    logic [7:0] DIV_DD;
    logic [3:0] DIV_DQ;
    logic [7:0] DIV_ANS;
    logic [3:0] DIV_ARE;
    logic       OUT_VALID;
    logic       OUT_READY = 1'b1;
    logic [7:0] OUT_Q;
    logic [3:0] OUT_R;
    logic       OUT_DZ;

    div_seq #(.DIV_LAT(LAT)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DD(IN_DD), .IN_DQ(IN_DQ),
        .DIV_START(DIV_START), .DIV_DD(DIV_DD), .DIV_DQ(DIV_DQ),
        .DIV_ANS(DIV_ANS), .DIV_ARE(DIV_ARE),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_Q(OUT_Q), .OUT_R(OUT_R), .OUT_DZ(OUT_DZ)
    );

    always #5 CLOCK = ~CLOCK;

    // Divider model: latches operands on the start edge, correct result only LAT cycles later.
    logic [7:0] m_dd;
    logic [3:0] m_dq;
    int         m_cnt;
    logic [7:0] tq;
    logic [3:0] tr;
    always @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            m_dd <= '0; m_dq <= 4'd1; m_cnt <= 0;
        end else if (DIV_START) begin
            m_dd <= DIV_DD; m_dq <= DIV_DQ; m_cnt <= LAT - 1;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
        end
    end
    assign tq      = (m_dq == 0) ? 8'h00 : m_dd / {4'b0, m_dq};
    assign tr      = (m_dq == 0) ? 4'h0 : 4'(m_dd % {4'b0, m_dq});
    assign DIV_ANS = (m_cnt == 0) ? tq : ~tq;
    assign DIV_ARE = (m_cnt == 0) ? tr : ~tr;

    int cyc = 0;
    always @(posedge CLOCK) cyc <= cyc + 1;

    int          checks = 0, errors = 0;
    int          n_start = 0, n_xfer = 0, start_cyc = 0, valid_cyc = 0;
    logic        pv = 1'b0;
    logic [12:0] exp_q[$];
    logic [12:0] e;

    // Monitor: event tracking plus scoreboard compare on each output handshake.
    always @(negedge CLOCK) begin
        if (DIV_START) begin n_start++; start_cyc = cyc; end
        if (OUT_VALID && !pv) valid_cyc = cyc;
        pv = OUT_VALID;
        if (OUT_VALID && OUT_READY && !RESET) begin
            n_xfer++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got q=%0d r=%0d dz=%0d, expected no result", OUT_Q, OUT_R, OUT_DZ);
            end else begin
                e = exp_q.pop_front();
                if ({OUT_Q, OUT_R, OUT_DZ} !== e) begin
                    errors++;
                    $display("FAIL result: got q=%0d r=%0d dz=%0d, expected q=%0d r=%0d dz=%0d",
                             OUT_Q, OUT_R, OUT_DZ, e[12:5], e[4:1], e[0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic send(input logic [7:0] dd, input logic [3:0] dq, input bit keep, output int acc);
        int n = 0;
        IN_DD = dd; IN_DQ = dq; IN_VALID = 1'b1;
        while (!IN_READY && n < 200) begin step(); n++; end
        if (n >= 200) begin errors++; checks++; $display("FAIL accept_timeout: got no IN_READY, expected accept"); end
        acc = cyc;
        step();
        if (!keep) IN_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !IN_READY) && n < 300) begin step(); n++; end
        if (n >= 300) begin errors++; checks++; $display("FAIL idle_timeout: got %0d pending, expected 0", exp_q.size()); end
    endtask

    function automatic logic [12:0] ref_model(input logic [7:0] dd, input logic [3:0] dq);
        if (dq == 0) return {8'hFF, 4'hF, 1'b1};
        return {8'(dd / dq), 4'(dd % dq), 1'b0};
    endfunction

    vec_t vecs[9];
    int   acc, prev_acc, s0, x0, nv;
    logic prev_dz, ok;
    logic [12:0] snap;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0};
        vecs[1] = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0};
        vecs[2] = '{8'd5,   4'd9,  8'd0,   4'd5,  1'b0};
        vecs[3] = '{8'd0,   4'd1,  8'd0,   4'd0,  1'b0};
        vecs[4] = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0};
        vecs[5] = '{8'd100, 4'd0,  8'hFF,  4'hF,  1'b1};
        vecs[6] = '{8'd123, 4'd5,  8'd24,  4'd3,  1'b0};
        vecs[7] = '{8'd17,  4'd4,  8'd4,   4'd1,  1'b0};
        vecs[8] = '{8'd99,  4'd10, 8'd9,   4'd9,  1'b0};
        #1 RESET = 1'b1;
        repeat (3) step();
        RESET = 1'b0;
        step();
        chk("rst_in_ready", IN_READY, 1);
        chk("rst_div_start", DIV_START, 0);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_out_dz", OUT_DZ, 0);
        chk("rst_out_qr", {OUT_Q, OUT_R}, 0);
        chk("rst_div_operands", {DIV_DD, DIV_DQ}, 0);
        // 200/7 with timing
        s0 = n_start;
        exp_q.push_back({vecs[0].q, vecs[0].r, vecs[0].dz});
        send(vecs[0].dd, vecs[0].dq, 0, acc);
        wait_idle();
        chk("start_count_200_7", n_start - s0, 1);
        chk("start_after_accept", start_cyc - acc, 1);
        chk("valid_after_start", valid_cyc - start_cyc, LAT + 1);
        // boundary values
        for (int i = 1; i <= 4; i++) begin
            s0 = n_start;
            exp_q.push_back({vecs[i].q, vecs[i].r, vecs[i].dz});
            send(vecs[i].dd, vecs[i].dq, 0, acc);
            wait_idle();
            chk("start_count_boundary", n_start - s0, 1);
        end
        // divide by zero
        s0 = n_start;
        exp_q.push_back({vecs[5].q, vecs[5].r, vecs[5].dz});
        send(vecs[5].dd, vecs[5].dq, 0, acc);
        wait_idle();
        chk("dz_no_start", n_start - s0, 0);
        chk("dz_valid_latency", valid_cyc - acc, 1);
        // backpressure
        OUT_READY = 1'b0;
        exp_q.push_back({8'd25, 4'd2, 1'b0});
        send(8'd77, 4'd3, 0, acc);
        nv = 0;
        while (!OUT_VALID && nv < 50) begin step(); nv++; end
        chk("bp_valid_seen", OUT_VALID, 1);
        snap = {OUT_Q, OUT_R, OUT_DZ};
        s0 = n_start;
        ok = 1'b1;
        IN_DD = 8'd9; IN_DQ = 4'd3; IN_VALID = 1'b1;
        repeat (20) begin
            step();
            if ({OUT_Q, OUT_R, OUT_DZ} !== snap || IN_READY || !OUT_VALID) ok = 1'b0;
        end
        chk("bp_hold", ok, 1);
        chk("bp_no_start", n_start - s0, 0);
        IN_VALID = 1'b0;
        x0 = n_xfer;
        OUT_READY = 1'b1;
        repeat (5) step();
        chk("bp_one_xfer", n_xfer - x0, 1);
        // reset in the 4th WAIT cycle of 123/5
        send(8'd123, 4'd5, 0, acc);
        repeat (3) step();
        @(posedge CLOCK);
        #2 RESET = 1'b1;
        #1;
        chk("async_rst_in_ready", IN_READY, 1);
        chk("async_rst_out_valid", OUT_VALID, 0);
        chk("async_rst_out_qr", {OUT_Q, OUT_R, OUT_DZ}, 0);
        chk("async_rst_div_operands", {DIV_DD, DIV_DQ, DIV_START}, 0);
        step();
        RESET = 1'b0;
        nv = 0;
        repeat (15) begin step(); if (OUT_VALID) nv++; end
        chk("abort_no_valid", nv, 0);
        exp_q.push_back({vecs[6].q, vecs[6].r, vecs[6].dz});
        send(vecs[6].dd, vecs[6].dq, 0, acc);
        wait_idle();
        // back-to-back: directed table then pseudo-random pairs
        prev_acc = 0; prev_dz = 1'b0;
        for (int i = 0; i < 15; i++) begin
            logic [7:0] dd;
            logic [3:0] dq;
            if (i < 9) begin dd = vecs[i].dd; dq = vecs[i].dq; end
            else begin dd = 8'($urandom_range(0, 255)); dq = 4'($urandom_range(0, 15)); end
            if (i == 12) dq = 4'd0;
            exp_q.push_back(i < 9 ? {vecs[i].q, vecs[i].r, vecs[i].dz} : ref_model(dd, dq));
            send(dd, dq, 1, acc);
            if (i > 0) chk("b2b_spacing", acc - prev_acc, prev_dz ? 2 : LAT + 3);
            prev_acc = acc;
            prev_dz = (dq == 0);
        end
        IN_VALID = 1'b0;
        wait_idle();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Operand sequencer and result capture stage for the 8/4 sequential divider. Upstream producers hand it a dividend/divisor pair over a valid/ready handshake. It loads the divider with a one-cycle start pulse and waits out the divider's fixed latency. It then captures quotient and remainder into an output register held under a second valid/ready handshake, and short-circuits divide-by-zero without starting the divider.

## Interface
Parameters:
- DIV_LAT, 10, cycles from the DIV_START cycle to the result-sampling edge (divider: load, 8 shift steps, final correction).
- DZ_Q, 8'hFF, quotient reported on divide-by-zero.
- DZ_R, 4'hF, remainder reported on divide-by-zero.

Ports. One clock; reset is asynchronous and active-high.
- CLOCK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  operand pair valid.
- IN_READY  out  1  sequencer can accept an operand pair.
- IN_DD  in  8  dividend.
- IN_DQ  in  4  divisor.
- DIV_START  out  1  one-cycle load/start pulse to the divider.
- DIV_DD  out  8  dividend to the divider; held stable from accept until the next accept.
- DIV_DQ  out  4  divisor to the divider; held stable the same way.
- DIV_ANS  in  8  divider quotient.
- DIV_ARE  in  4  divider remainder.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer takes the result.
- OUT_Q  out  8  quotient.
- OUT_R  out  4  remainder.
- OUT_DZ  out  1  result is a divide-by-zero substitute.

## Operation
- FSM states are IDLE, START, WAIT and DONE.
- IDLE:
  - IN_READY=1.
  - On IN_VALID, capture IN_DD/IN_DQ into the operand registers.
  - If IN_DQ==0, go to DONE with OUT_Q=DZ_Q, OUT_R=DZ_R and OUT_DZ=1. The divider is never started.
  - Otherwise go to START.
- START: DIV_START=1 for exactly this cycle. Load the latency counter with DIV_LAT-1. Go to WAIT.
- WAIT:
  - The counter decrements each cycle.
  - At count 0, sample DIV_ANS into OUT_Q and DIV_ARE into OUT_R, clear OUT_DZ, and go to DONE.
- DONE:
  - OUT_VALID=1. OUT_Q, OUT_R and OUT_DZ are stable.
  - On OUT_READY, go to IDLE.
- IN_READY is 0 in START, WAIT and DONE. There is no operand queuing.
- No arithmetic is done here. Results pass through bit-exact.
- Reset values:
  - State is IDLE.
  - IN_READY=1 once reset deasserts.
  - DIV_START, OUT_VALID and OUT_DZ are 0.
  - OUT_Q, OUT_R, DIV_DD, DIV_DQ and the counter are 0.

## Timing
- Accept occurs at the edge where IN_VALID & IN_READY. Call the following cycle S; DIV_START is high in cycle S only.
- The result is sampled on the edge ending cycle S+DIV_LAT. OUT_VALID rises in cycle S+DIV_LAT+1.
- With OUT_READY tied high and IN_VALID always high:
  - Non-zero divisor: one accept per DIV_LAT+3 cycles (13 by default).
  - Zero divisor: OUT_VALID appears in the cycle after accept, giving one accept per 2 cycles.
- OUT_VALID deasserts in the cycle after the output handshake edge. IN_READY reasserts in that same cycle.
- Backpressure: while OUT_VALID & ~OUT_READY, outputs do not change and IN_READY stays 0.
- DIV_DD/DIV_DQ are registered from accept and unchanged through START and WAIT. The divider sees them stable at the DIV_START edge.
- Reset mid-operation (any state):
  - Immediate return to IDLE with all outputs at reset values.
  - An in-flight result is discarded and never presented.
  - The system reset also clears the divider, so the next operation starts clean.
- DIV_LAT must be at least 1. The counter width is $clog2(DIV_LAT)+1.

## Structure
- Shared package div_pkg:
  - state enum (IDLE, START, WAIT, DONE);
  - default DIV_LAT constant;
  - DZ_Q/DZ_R defaults;
  - operand/result widths (8, 4).
  The divider top also uses the widths.
- One natural sub-module: div_lat_cnt, a loadable down-counter with a zero flag. It is reusable for other fixed-latency sequential units.
- Everything else is a single FSM plus capture registers in div_seq.

## Test plan
- 200/7 (IN_DD=8'd200, IN_DQ=4'd7):
  - DIV_START pulses once, one cycle after accept.
  - OUT_Q=8'd28, OUT_R=4'd4, OUT_DZ=0.
  - OUT_VALID is high exactly 11 cycles after DIV_START.
- Boundary values:
  - 255/15 gives Q=17, R=0.
  - 5/9 gives Q=0, R=5.
  - 0/1 gives Q=0, R=0.
  - 255/1 gives Q=255, R=0.
- 100/0:
  - DIV_START never asserts.
  - OUT_Q=8'hFF, OUT_R=4'hF, OUT_DZ=1.
  - OUT_VALID appears in the cycle after accept.
- Backpressure: OUT_READY low for 20 cycles after OUT_VALID.
  - OUT_Q/OUT_R/OUT_DZ stay constant.
  - IN_READY stays 0 and no new DIV_START occurs.
  - Release gives exactly one transfer.
- Reset pulse in the 4th WAIT cycle of 123/5:
  - All outputs return to reset values asynchronously.
  - No OUT_VALID appears for that operation.
  - A following 123/5 returns Q=24, R=3.
- Back-to-back random pairs with OUT_READY=1 and IN_VALID=1:
  - Accepts are spaced 13 cycles apart.
  - Every result matches a dd/dq, dd%dq reference model, with zero-divisor pairs matching DZ values.
